// File: rtl/song_reader_pkg.sv
// Shared widths, state encoding and rom_data field layout for the song reader.
// Pure declarations: no logic, no latency.
package song_reader_pkg;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int SKIP   = 4;
    localparam int SONG_W = 2;

    localparam int DUR_LSB  = 0;
    localparam int DUR_MSB  = DUR_W - 1;
    localparam int NOTE_LSB = DUR_W;
    localparam int NOTE_MSB = DUR_W + NOTE_W - 1;

    localparam logic [DUR_W-1:0] END_MARK = '0;
    localparam logic [IDX_W-1:0] IDX_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        WAIT  = 2'd3
    } state_t;
endpackage

// File: rtl/song_reader_if.sv
// Control-unit, ROM and note-player signals of the song reader.
// slave = song_reader side, master = environment driving it.
interface song_reader_if;
    import song_reader_pkg::*;

    logic                      play;
    logic                      rewind;
    logic                      ff;
    logic                      reset_player;
    logic [SONG_W-1:0]         song;
    logic                      note_done;
    logic [SONG_W+IDX_W-1:0]   rom_addr;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic [NOTE_W-1:0]         note;
    logic [DUR_W-1:0]          duration;
    logic                      new_note;
    logic                      song_done;

    modport slave (
        input  play, rewind, ff, reset_player, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done
    );

    modport master (
        output play, rewind, ff, reset_player, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done
    );
endinterface

// File: rtl/dffr.sv
// Resettable flops: dffr always loads, dffre loads only when en_i is set.
// One cycle d->q, asynchronous active-high reset to zero.
module dffr #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_o <= '0;
        else       q_o <= d_i;
    end
endmodule

module dffre #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     q_o <= '0;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/song_index_ctr.sv
// Note index: clear > saturating rewind > forward skip (wraps to 0 on overflow) > increment.
// Updates one cycle after the request; ovf_o is combinational on the current index.
module song_index_ctr
    import song_reader_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             sub_i,
    input  logic             add_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             ovf_o
);
    localparam logic [IDX_W-1:0] SKIP_V = IDX_W'(SKIP);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   sum;
    logic             en;

    // One extra bit so idx+SKIP past the last note is visible as a carry.
    assign sum   = {1'b0, idx_q} + {1'b0, SKIP_V};
    assign ovf_o = sum[IDX_W];
    assign en    = clr_i | inc_i | sub_i | add_i;
    assign idx_o = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i)      idx_d = '0;
        else if (sub_i) idx_d = (idx_q >= SKIP_V) ? idx_q - SKIP_V : '0;
        else if (add_i) idx_d = ovf_o ? '0 : sum[IDX_W-1:0];
        else if (inc_i) idx_d = idx_q + IDX_W'(1);
    end

    dffre #(.W(IDX_W)) u_idx (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en),
        .d_i   (idx_d),
        .q_o   (idx_q)
    );
endmodule

// File: rtl/song_reader.sv
// Walks a song's note list in an external synchronous ROM and presents note/duration with new_note.
// new_note three cycles after play in IDLE; no backpressure, note_done advances the index.
module song_reader
    import song_reader_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    song_reader_if.slave bus
);
    logic [1:0]        state_bits;
    state_t            state_q, state_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              new_note_q, new_note_d;
    logic              song_done_q, song_done_d;

    logic             idx_clr, idx_inc, idx_sub, idx_add, idx_ovf;
    logic [IDX_W-1:0] idx;
    logic [DUR_W-1:0]  rom_dur;
    logic [NOTE_W-1:0] rom_note;

    assign state_q  = state_t'(state_bits);
    assign rom_dur  = bus.rom_data[DUR_MSB:DUR_LSB];
    assign rom_note = bus.rom_data[NOTE_MSB:NOTE_LSB];

    assign bus.rom_addr  = {bus.song, idx};
    assign bus.note      = note_q;
    assign bus.duration  = dur_q;
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;

    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        idx_sub     = 1'b0;
        idx_add     = 1'b0;

        // Transport controls abort whatever is in flight and park in IDLE.
        if (bus.reset_player) begin
            idx_clr = 1'b1;
            note_d  = '0;
            dur_d   = '0;
            state_d = IDLE;
        end else if (bus.rewind) begin
            idx_sub = 1'b1;
            state_d = IDLE;
        end else if (bus.ff) begin
            idx_add     = 1'b1;
            song_done_d = idx_ovf;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (bus.play) state_d = FETCH;
                FETCH: state_d = LATCH;
                LATCH: begin
                    if (rom_dur == END_MARK) begin
                        song_done_d = 1'b1;
                        idx_clr     = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        note_d     = rom_note;
                        dur_d      = rom_dur;
                        new_note_d = 1'b1;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.note_done) begin
                        if (idx == IDX_MAX) begin
                            song_done_d = 1'b1;
                            idx_clr     = 1'b1;
                        end else begin
                            idx_inc = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    song_index_ctr u_idx (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (idx_clr),
        .inc_i (idx_inc),
        .sub_i (idx_sub),
        .add_i (idx_add),
        .idx_o (idx),
        .ovf_o (idx_ovf)
    );

    dffr #(.W(2))      u_state (.clk_i(clk), .rst_i(reset), .d_i(state_d),     .q_o(state_bits));
    dffr #(.W(NOTE_W)) u_note  (.clk_i(clk), .rst_i(reset), .d_i(note_d),      .q_o(note_q));
    dffr #(.W(DUR_W))  u_dur   (.clk_i(clk), .rst_i(reset), .d_i(dur_d),       .q_o(dur_q));
    dffr #(.W(1))      u_nn    (.clk_i(clk), .rst_i(reset), .d_i(new_note_d),  .q_o(new_note_q));
    dffr #(.W(1))      u_sd    (.clk_i(clk), .rst_i(reset), .d_i(song_done_d), .q_o(song_done_q));
endmodule
